// File: rtl/spad_qr_seq.sv
// Multi-channel SPAD quench/hold-off/recharge sequencer with saturating photon
// counters and heartbeat/status LEDs. Each channel runs an independent FSM.
module spad_qr_seq #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned TW     = 8,
  parameter int unsigned CW     = 16,
  parameter int unsigned HB_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_CH-1:0]    det,
  input  logic [TW-1:0]      t_quench,
  input  logic [TW-1:0]      t_hold,
  input  logic [TW-1:0]      t_reset,
  input  logic               clr_cnt,
  output logic [N_CH-1:0]    quench,
  output logic [N_CH-1:0]    reset,
  output logic [N_CH-1:0]    armed,
  output logic [N_CH*CW-1:0] cnt,
  output logic [N_CH-1:0]    cnt_ovf,
  output logic               geiger_mode_en,
  output logic [3:0]         led
);

  localparam int unsigned HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_QUENCH = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RST    = 3'd4;

  logic [2:0]      state_q [N_CH];
  logic [2:0]      state_d [N_CH];
  logic [TW-1:0]   tmr_q   [N_CH];
  logic [TW-1:0]   tmr_d   [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] go;
  logic [N_CH-1:0] quench_q, reset_q, armed_q;
  logic            geiger_q;
  logic [3:0]      led_q;
  logic [HB_W-1:0] hb_q;
  logic [TW-1:0]   tq_m1, tr_m1;

  // Timer reload values: a zero length behaves as a single cycle.
  always_comb begin
    tq_m1 = (t_quench == '0) ? '0 : t_quench - TW'(1);
    tr_m1 = (t_reset  == '0) ? '0 : t_reset  - TW'(1);
  end

  // Per-channel next state; a detection is registered in pend and acted on one edge later.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      pend_d[i]  = 1'b0;
      go[i]      = 1'b0;
      if (!en) begin
        state_d[i] = S_IDLE;
        tmr_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_IDLE:   state_d[i] = S_ARMED;
          S_ARMED: begin
            if (pend_q[i]) begin
              state_d[i] = S_QUENCH;
              tmr_d[i]   = tq_m1;
              go[i]      = 1'b1;
            end else begin
              pend_d[i]  = det[i];
            end
          end
          S_QUENCH: begin
            if (tmr_q[i] != '0) begin
              tmr_d[i] = tmr_q[i] - TW'(1);
            end else if (t_hold == '0) begin
              state_d[i] = S_RST;
              tmr_d[i]   = tr_m1;
            end else begin
              state_d[i] = S_HOLD;
              tmr_d[i]   = t_hold - TW'(1);
            end
          end
          S_HOLD: begin
            if (tmr_q[i] != '0) begin
              tmr_d[i] = tmr_q[i] - TW'(1);
            end else begin
              state_d[i] = S_RST;
              tmr_d[i]   = tr_m1;
            end
          end
          S_RST: begin
            if (tmr_q[i] != '0) tmr_d[i] = tmr_q[i] - TW'(1);
            else                state_d[i] = S_ARMED;
          end
          default: begin
            state_d[i] = S_IDLE;
            tmr_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Saturating photon counters; a clear coinciding with a detection leaves a count of one.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (go[i]) begin
        if (clr_cnt) begin
          cnt_d[i] = CW'(1);
          ovf_d[i] = 1'b0;
        end else if (cnt_q[i] == {CW{1'b1}}) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else if (clr_cnt) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        tmr_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      pend_q   <= '0;
      ovf_q    <= '0;
      quench_q <= '0;
      reset_q  <= '0;
      armed_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= state_d[i];
        tmr_q[i]    <= tmr_d[i];
        cnt_q[i]    <= cnt_d[i];
        quench_q[i] <= (state_d[i] == S_QUENCH);
        reset_q[i]  <= (state_d[i] == S_RST);
        armed_q[i]  <= (state_d[i] == S_ARMED);
      end
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Heartbeat divider and status LEDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q     <= '0;
      led_q    <= '0;
      geiger_q <= 1'b0;
    end else begin
      geiger_q <= en;
      if (hb_q == HB_W'(HB_DIV - 1)) begin
        hb_q     <= '0;
        led_q[3] <= ~led_q[3];
      end else begin
        hb_q     <= hb_q + HB_W'(1);
      end
      led_q[2:0] <= {|quench_q, |reset_q, geiger_q};
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign cnt[g*CW +: CW] = cnt_q[g];
  end

  assign quench         = quench_q;
  assign reset          = reset_q;
  assign armed          = armed_q;
  assign cnt_ovf        = ovf_q;
  assign geiger_mode_en = geiger_q;
  assign led            = led_q;

endmodule

// File: tb/tb_spad_qr_seq.sv
// Scoreboard bench for spad_qr_seq: a timeline-based reference model predicts
// every output each cycle; a monitor compares the DUT against the queued predictions.
module tb_spad_qr_seq;

  localparam int N  = 4;
  localparam int TW = 8;
  localparam int CW = 4;
  localparam int HB = 4;
  localparam int VW = 3*N + N*CW + N + 1 + 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en, clr_cnt;
  logic [N-1:0]    det;
  logic [TW-1:0]   t_quench, t_hold, t_reset;
  logic [N-1:0]    quench, reset, armed, cnt_ovf;
  logic [N*CW-1:0] cnt;
  logic            geiger_mode_en;
  logic [3:0]      led;

  always #5 clk = ~clk;

  spad_qr_seq #(.N_CH(N), .TW(TW), .CW(CW), .HB_DIV(HB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .det(det),
    .t_quench(t_quench), .t_hold(t_hold), .t_reset(t_reset), .clr_cnt(clr_cnt),
    .quench(quench), .reset(reset), .armed(armed), .cnt(cnt), .cnt_ovf(cnt_ovf),
    .geiger_mode_en(geiger_mode_en), .led(led)
  );

  logic [VW-1:0] dut_v;
  assign dut_v = {quench, reset, armed, cnt, cnt_ovf, geiger_mode_en, led};

  logic [VW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each channel is described by absolute edge numbers of its
  // quench end, recharge start and recharge end.
  longint m_n;
  bit     m_idle [N];
  bit     m_armed[N];
  bit     m_pend [N];
  bit     m_busy [N];
  longint m_qe[N], m_rs[N], m_re[N];
  int     m_cnt[N];
  bit     m_ovf[N];
  bit [2:0] m_led_prev;

  function automatic int max1(input logic [TW-1:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  function automatic bit m_quenching(input int i);
    return m_busy[i] && (m_n < m_qe[i]);
  endfunction

  function automatic bit m_recharging(input int i);
    return m_busy[i] && (m_re[i] >= 0) && (m_n >= m_rs[i]);
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_led_prev = '0;
    for (int i = 0; i < N; i++) begin
      m_idle[i] = 1; m_armed[i] = 0; m_pend[i] = 0; m_busy[i] = 0;
      m_qe[i] = -1; m_rs[i] = -1; m_re[i] = -1;
      m_cnt[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] eq, er, ea, eo;
    logic [N*CW-1:0] ec;
    bit trig;
    m_n++;
    for (int i = 0; i < N; i++) begin
      trig = 0;
      if (!en) begin
        m_idle[i] = 1; m_armed[i] = 0; m_pend[i] = 0; m_busy[i] = 0;
      end else if (m_idle[i]) begin
        m_idle[i] = 0; m_armed[i] = 1;
      end else if (m_armed[i]) begin
        if (m_pend[i]) begin
          trig = 1; m_armed[i] = 0; m_pend[i] = 0; m_busy[i] = 1;
          m_qe[i] = m_n + max1(t_quench); m_rs[i] = -1; m_re[i] = -1;
        end else begin
          m_pend[i] = det[i];
        end
      end else if (m_busy[i]) begin
        if (m_n == m_qe[i]) m_rs[i] = m_n + int'(t_hold);
        if (m_rs[i] >= 0 && m_n == m_rs[i]) m_re[i] = m_n + max1(t_reset);
        if (m_re[i] >= 0 && m_n == m_re[i]) begin
          m_busy[i] = 0; m_armed[i] = 1;
        end
      end
      if (trig) begin
        if (clr_cnt) begin m_cnt[i] = 1; m_ovf[i] = 0; end
        else if (m_cnt[i] == (1 << CW) - 1) m_ovf[i] = 1;
        else m_cnt[i]++;
      end else if (clr_cnt) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end
      eq[i] = m_quenching(i);
      er[i] = m_recharging(i);
      ea[i] = m_armed[i];
      eo[i] = m_ovf[i];
      ec[i*CW +: CW] = CW'(m_cnt[i]);
    end
    exp_q.push_back({eq, er, ea, ec, eo, en, 1'((m_n / HB) % 2), m_led_prev});
    m_led_prev = {|eq, |er, en};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // Monitor: every clocked cycle out of reset presents a full output word.
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        #1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL outputs t=%0t: got %h, no expected value queued", $time, dut_v);
        end else begin
          e = exp_q.pop_front();
          if (dut_v !== e) begin
            n_err++;
            $display("FAIL outputs t=%0t: got %h expected %h (q r a cnt ovf gme led)", $time, dut_v, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_quench(input int ch);
    for (int k = 0; k < 40 && !m_quenching(ch); k++) @(negedge clk);
    check("wait_quench_timeout", 64'(m_quenching(ch)), 64'd1);
  endtask

  task automatic wait_recharge(input int ch);
    for (int k = 0; k < 40 && !m_recharging(ch); k++) @(negedge clk);
    check("wait_recharge_timeout", 64'(m_recharging(ch)), 64'd1);
  endtask

  task automatic wait_pend(input int ch);
    for (int k = 0; k < 40 && !(m_armed[ch] && m_pend[ch]); k++) @(negedge clk);
    check("wait_pend_timeout", 64'(m_armed[ch] && m_pend[ch]), 64'd1);
  endtask

  task automatic set_t(input int q, input int h, input int r);
    t_quench = TW'(q); t_hold = TW'(h); t_reset = TW'(r);
  endtask

  initial begin
    en = 0; det = '0; clr_cnt = 0;
    set_t(3, 2, 4);
    #3;
    check("reset_state", 64'(dut_v), 64'd0);
    step(2);
    rst_n = 1;
    step(2);
    en = 1;
    step(3);
    // Single pulse on channel 0, 3/2/4 timing
    det = 4'b0001; step(1); det = '0; step(16);
    // Zero timing: one quench cycle straight into one recharge cycle
    set_t(0, 0, 0);
    det = 4'b0100; step(1); det = '0; step(6);
    // Timing changes while a sequence is running
    set_t(3, 2, 4);
    det = 4'b0001; step(2); det = '0;
    wait_quench(0); t_hold = 8'd5; t_reset = 8'd1; step(2);
    t_quench = 8'd1; step(3); t_reset = 8'd6; step(14);
    // Held detector on channel 1 retriggers repeatedly
    set_t(3, 2, 4);
    det = 4'b0010; step(20); det = '0; step(14);
    // Saturation on channel 3, then clear coinciding with a detection
    set_t(0, 0, 0);
    det = 4'b1000; step(80);
    wait_pend(3); clr_cnt = 1; step(1); clr_cnt = 0;
    step(2); det = '0; step(6);
    // Simultaneous detections on all channels
    set_t(2, 1, 2);
    det = 4'b1111; step(1); det = '0; step(10);
    // Enable dropped during quench
    set_t(3, 2, 4);
    det = 4'b0001; step(1); det = '0;
    wait_quench(0); en = 0; step(3); en = 1; step(3);
    // Asynchronous reset during recharge
    det = 4'b0001; step(1); det = '0;
    wait_recharge(0);
    #2 rst_n = 0;
    #1;
    check("async_rst_reset", 64'(reset), 64'd0);
    check("async_rst_quench", 64'(quench), 64'd0);
    check("async_rst_cnt", 64'(cnt), 64'd0);
    check("async_rst_armed_led", 64'({armed, led}), 64'd0);
    @(negedge clk); rst_n = 1;
    step(4);
    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) det[i] = ($urandom_range(7) == 0);
      en = ($urandom_range(63) != 0);
      clr_cnt = ($urandom_range(49) == 0);
      if ($urandom_range(15) == 0) set_t($urandom_range(5), $urandom_range(5), $urandom_range(5));
    end
    @(negedge clk);
    en = 1; det = '0; clr_cnt = 0;
    step(30);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
